draw_cmd_sequencer: RTL and testbench

//  Initiator side of the plotter go/done handshake. Buffers draw commands
//  (x0,y0,x1,y1,colour) from the CPU bus in a small FIFO and issues them one
//  at a time to the line/box plotter controller with a four-phase go/done

---
 rtl/draw_seq_pkg.sv | 31 +++
 rtl/draw_cmd_fifo.sv | 73 +++++++
 rtl/draw_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_draw_cmd_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_seq_pkg.sv
// ---------------------------------------------------------------------------
// draw_seq_pkg
// Shared definitions for the draw command sequencer:
//   - default widths / depth / watchdog limit
//   - sequencer state encoding (IDLE, LOAD, REQ, RELEASE)
//   - command record layout helper. A command is packed as
//     {colour, y1, x1, y0, x0}, x0 in the least significant bits.
// Optional feature macro used by the top: DRAW_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package draw_seq_pkg;

    localparam int X_W_DEF        = 8;
    localparam int Y_W_DEF        = 7;
    localparam int COLOUR_W_DEF   = 3;
    localparam int DEPTH_DEF      = 4;
    localparam int TIMEOUT_DEF    = 4096;
    localparam int TMO_CNT_W      = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Width of one packed command record {colour, y1, x1, y0, x0}.
    function automatic int cmd_width(input int xw, input int yw, input int cw);
        return cw + 2 * yw + 2 * xw;
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// ---------------------------------------------------------------------------
// draw_cmd_fifo
// DEPTH-entry circular buffer holding packed draw commands.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i         write wr_data_i this cycle (caller qualifies with ready_o)
//   wr_data_i      packed command
//   pop_i          drop the head entry this cycle (caller guarantees count>0)
//   rd_data_o      head entry (combinational read)
//   count_o        number of stored entries, 0..DEPTH
//   ready_o        1 when count < DEPTH; does not look at a same-cycle pop
// DEPTH must be a power of two so pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
import draw_seq_pkg::*;

module draw_cmd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ready_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign ready_o   = (count_q != CNT_W'(DEPTH));

endmodule

// File: rtl/draw_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// draw_cmd_sequencer
// Buffers CPU draw commands and issues them one at a time to the plotter
// using a four-phase go/done handshake.
// Handshakes:
//   cmd side : a command is accepted on a rising edge where
//              cmd_valid && cmd_ready; cmd_ready = FIFO count < DEPTH.
//   plotter  : go rises (REQ) with draw_* already stable; the plotter raises
//              done when finished; go then falls (RELEASE); the plotter must
//              drop done before the next go. A new request is never started
//              while done is still high.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    CPU command handshake
//   cmd_x0..cmd_colour       command fields
//   go / done                plotter handshake
//   draw_x0..draw_colour     command under execution, stable while go=1
//   busy                     state != IDLE or FIFO non-empty
//   done_count               completed commands, wraps 255 -> 0
//   timeout_err              sticky watchdog flag (0 unless DRAW_TIMEOUT_EN)
//   state_dbg, count_dbg     FSM state and FIFO occupancy for observation
// Optional feature macro: DRAW_TIMEOUT_EN enables the REQ watchdog; after
// TIMEOUT_CYCLES cycles in REQ with no done the request is abandoned.
// ---------------------------------------------------------------------------
import draw_seq_pkg::*;

module draw_cmd_sequencer #(
    parameter int X_W            = X_W_DEF,
    parameter int Y_W            = Y_W_DEF,
    parameter int COLOUR_W       = COLOUR_W_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [X_W-1:0]         cmd_x0,
    input  logic [Y_W-1:0]         cmd_y0,
    input  logic [X_W-1:0]         cmd_x1,
    input  logic [Y_W-1:0]         cmd_y1,
    input  logic [COLOUR_W-1:0]    cmd_colour,
    output logic                   go,
    input  logic                   done,
    output logic [X_W-1:0]         draw_x0,
    output logic [Y_W-1:0]         draw_y0,
    output logic [X_W-1:0]         draw_x1,
    output logic [Y_W-1:0]         draw_y1,
    output logic [COLOUR_W-1:0]    draw_colour,
    output logic                   busy,
    output logic [7:0]             done_count,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg,
    output logic [$clog2(DEPTH):0] count_dbg
);

    localparam int CMD_W = cmd_width(X_W, Y_W, COLOUR_W);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             push, pop;
    logic [CMD_W-1:0] wr_data, head;
    logic [CNT_W-1:0] count;

    state_e           state_q, state_d;
    logic [CMD_W-1:0] draw_q, draw_d;
    logic [7:0]       done_count_q, done_count_d;
    logic             tmo_hit;

    assign wr_data = {cmd_colour, cmd_y1, cmd_x1, cmd_y0, cmd_x0};
    assign push    = cmd_valid && cmd_ready;

    draw_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (wr_data),
        .pop_i     (pop),
        .rd_data_o (head),
        .count_o   (count),
        .ready_o   (cmd_ready)
    );

`ifdef DRAW_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    // Counter is zero on the first REQ cycle, so hitting TMO_LAST means
    // TIMEOUT_CYCLES REQ cycles have elapsed. done wins a tie.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d     = (state_q == ST_REQ) ? tmo_cnt_q + TMO_CNT_W'(1) : '0;
        timeout_err_d = timeout_err_q | ((state_q == ST_REQ) && !done && tmo_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // State register (with the registers that only move on FSM transitions).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            draw_q       <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            draw_q       <= draw_d;
            done_count_q <= done_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        draw_d       = draw_q;
        done_count_d = done_count_q;
        pop          = 1'b0;
        case (state_q)
            // A stale done (e.g. after reset mid-draw) blocks new requests.
            ST_IDLE:    if ((count != '0) && !done) state_d = ST_LOAD;
            ST_LOAD: begin
                pop     = 1'b1;
                draw_d  = head;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (done) begin
                    state_d      = ST_RELEASE;
                    done_count_d = done_count_q + 8'd1;
                end else if (tmo_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: if (!done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        go         = (state_q == ST_REQ);
        busy       = (state_q != ST_IDLE) || (count != '0);
        {draw_colour, draw_y1, draw_x1, draw_y0, draw_x0} = draw_q;
        done_count = done_count_q;
        state_dbg  = state_q;
        count_dbg  = count;
    end

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_draw_cmd_sequencer
// Self-checking bench: commands are pushed into exp_q as they are accepted
// and popped/compared when go rises; a small plotter model answers done.
// ---------------------------------------------------------------------------
module tb_draw_cmd_sequencer;
  import draw_seq_pkg::*;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int CMD_W = 33;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [X_W-1:0]   cmd_x0 = '0, cmd_x1 = '0;
  logic [Y_W-1:0]   cmd_y0 = '0, cmd_y1 = '0;
  logic [C_W-1:0]   cmd_colour = '0;
  logic             go;
  logic             done = 1'b0;
  logic [X_W-1:0]   draw_x0, draw_x1;
  logic [Y_W-1:0]   draw_y0, draw_y1;
  logic [C_W-1:0]   draw_colour;
  logic             busy;
  logic [7:0]       done_count;
  logic             timeout_err;
  logic [1:0]       state_dbg;
  logic [CNT_W-1:0] count_dbg;

  int               errors = 0;
  int               checks = 0;
  logic [CMD_W-1:0] exp_q[$];
  logic [7:0]       exp_done_cnt = '0;

  draw_cmd_sequencer #(
    .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_colour(cmd_colour),
    .go(go), .done(done),
    .draw_x0(draw_x0), .draw_y0(draw_y0), .draw_x1(draw_x1), .draw_y1(draw_y1),
    .draw_colour(draw_colour),
    .busy(busy), .done_count(done_count), .timeout_err(timeout_err),
    .state_dbg(state_dbg), .count_dbg(count_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_done_cnt = '0;
  endtask

  function automatic logic [CMD_W-1:0] draw_vec();
    return {draw_colour, draw_y1, draw_x1, draw_y0, draw_x0};
  endfunction

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [7:0] x0);
    logic [2:0] c;
    logic [6:0] y1, y0;
    logic [7:0] x1;
    c  = 3'($urandom_range(0, 7));
    y1 = 7'($urandom_range(0, 127));
    x1 = 8'($urandom_range(0, 255));
    y0 = 7'($urandom_range(0, 127));
    return {c, y1, x1, y0, x0};
  endfunction

  // driver: waits (bounded) for cmd_ready, pushes one command, records it
  task automatic push_cmd(input logic [CMD_W-1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL push_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end else begin
      {cmd_colour, cmd_y1, cmd_x1, cmd_y0, cmd_x0} = c;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      exp_q.push_back(c);
    end
  endtask

  // bounded wait for go high, sampled on negedges
  task automatic wait_go(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (go !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 500);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL go_timeout: go=%b required 1", go);
    end
  endtask

  // plotter model + scoreboard pop: compare draw_* when go is high,
  // answer done after `delay` cycles, drop done once go falls
  task automatic serve(input int delay);
    bit ok;
    int n;
    logic [CMD_W-1:0] e;
    wait_go(ok);
    if (ok) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_go: draw=%h required no request", draw_vec());
      end else begin
        e = exp_q.pop_front();
        if (draw_vec() !== e) begin
          errors++;
          $display("FAIL draw_cmd: draw=%h required %h", draw_vec(), e);
        end
      end
      repeat (delay) @(posedge clk);
      #1 done = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (go === 1'b1 && n < 100);
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL go_release_timeout: go=%b required 0", go);
      end
      done = 1'b0;
      exp_done_cnt = exp_done_cnt + 8'd1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b required 0", go); end
    checks++; if (draw_vec() !== '0) begin errors++; $display("FAIL reset_draw: got %h required 0", draw_vec()); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL reset_done_count: got %0d required 0", done_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b required 0", timeout_err); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
  endtask

  task automatic test_single();
    logic [CMD_W-1:0] c;
    c = {3'd3, 7'd20, 8'd50, 7'd5, 8'd10};
    push_cmd(c);
    @(negedge clk);
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL single_go_edge1: got %b required 0", go); end
    @(negedge clk);
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL single_go_edge2: got %b required 0", go); end
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL single_load_state: got %0d required 1", state_dbg); end
    @(negedge clk);
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL single_go_latency: got %b required 1", go); end
    serve(6);
    repeat (2) @(negedge clk);
    checks++; if (done_count !== 8'd1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    push_cmd(mk_cmd(8'd100));
    wait_go(ok);
    for (int i = 1; i <= 4; i++) push_cmd(mk_cmd(8'(i)));
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b required 0", cmd_ready); end
    checks++; if (count_dbg !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", count_dbg); end
    // fifth command offered while full must be dropped
    {cmd_colour, cmd_y1, cmd_x1, cmd_y0, cmd_x0} = mk_cmd(8'd5);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (count_dbg !== 3'd4) begin errors++; $display("FAIL full_no_push: got %0d required 4", count_dbg); end
    for (int i = 0; i < 5; i++) serve(int'($urandom_range(0, 4)));
    repeat (2) @(negedge clk);
    checks++; if (done_count !== exp_done_cnt) begin errors++; $display("FAIL full_done_count: got %0d required %0d", done_count, exp_done_cnt); end
  endtask

  task automatic test_push_pop_same();
    bit ok;
    logic [CMD_W-1:0] e;
    push_cmd(mk_cmd(8'd200));
    wait_go(ok);
    for (int i = 0; i < 3; i++) push_cmd(mk_cmd(8'(201 + i)));
    // finish the in-flight command by hand to line up the LOAD cycle
    e = exp_q.pop_front();
    checks++; if (draw_vec() !== e) begin errors++; $display("FAIL pp_first_draw: got %h required %h", draw_vec(), e); end
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    exp_done_cnt = exp_done_cnt + 8'd1;
    @(posedge clk);
    @(posedge clk); #1;
    e = mk_cmd(8'd210);
    {cmd_colour, cmd_y1, cmd_x1, cmd_y0, cmd_x0} = e;
    cmd_valid = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL pp_in_load: got %0d required 1", state_dbg); end
    checks++; if (count_dbg !== 3'd3) begin errors++; $display("FAIL pp_count_before: got %0d required 3", count_dbg); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    checks++; if (count_dbg !== 3'd3) begin errors++; $display("FAIL pp_count_after: got %0d required 3", count_dbg); end
    for (int i = 0; i < 4; i++) serve(int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_mid_req();
    bit ok, saw_go;
    push_cmd(mk_cmd(8'd50));
    wait_go(ok);
    push_cmd(mk_cmd(8'd51));
    push_cmd(mk_cmd(8'd52));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_done_cnt = '0;
    @(negedge clk);
    checks++; if (go !== 1'b0) begin errors++; $display("FAIL rstreq_go: got %b required 0", go); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstreq_busy: got %b required 0", busy); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL rstreq_done_count: got %0d required 0", done_count); end
    done = 1'b1;
    push_cmd(mk_cmd(8'd60));
    saw_go = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (go === 1'b1) saw_go = 1'b1;
    end
    checks++; if (saw_go !== 1'b0) begin errors++; $display("FAIL stale_done_go: got go=%b required 0", saw_go); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stale_done_busy: got %b required 1", busy); end
    done = 1'b0;
    serve(2);
    checks++; if (done_count !== 8'd1) begin errors++; $display("FAIL rstreq_after_count: got %0d required 1", done_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push_cmd(mk_cmd(8'($urandom_range(0, 255))));
      serve(int'($urandom_range(0, 2)));
      if (i == 254) begin
        checks++; if (done_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d required 255", done_count); end
      end
    end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d required 0", done_count); end
    checks++; if (done_count !== exp_done_cnt) begin errors++; $display("FAIL wrap_model: got %0d required %0d", done_count, exp_done_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    logic [CMD_W-1:0] e;
    push_cmd(mk_cmd(8'd77));
    wait_go(ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (draw_vec() !== e) begin errors++; $display("FAIL tmo_draw: got %h required %h", draw_vec(), e); end
`ifdef DRAW_TIMEOUT_EN
      n = 0;
      while (go === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      checks++; if (n !== TMO) begin errors++; $display("FAIL tmo_go_cycles: got %0d required %0d", n, TMO); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", timeout_err); end
      checks++; if (done_count !== exp_done_cnt) begin errors++; $display("FAIL tmo_done_count: got %0d required %0d", done_count, exp_done_cnt); end
      repeat (3) @(negedge clk);
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b required 1", timeout_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b required 0", busy); end
`else
      n = 0;
      repeat (80) @(negedge clk);
      checks++; if (go !== 1'b1) begin errors++; $display("FAIL notmo_go_held: got %b required 1", go); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL notmo_err: got %b required 0", timeout_err); end
      exp_q.push_front(e);
      serve(n);
      checks++; if (done_count !== exp_done_cnt) begin errors++; $display("FAIL notmo_done_count: got %0d required %0d", done_count, exp_done_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_push_pop_same();
    test_reset_mid_req();
    test_wrap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
